// File: rtl/mac_dot_product_feeder_if.sv
// Operand/result bus between the fetch path, the MAC feeder and the MAC core.
// The feeder sits on the slave modport; the environment drives the master side.
interface mac_dot_product_feeder_if #(
    parameter int CNT_W = 16
);
    logic             s_valid;
    logic             s_ready;
    logic [31:0]      s_a;
    logic [31:0]      s_b;
    logic             s_last;
    logic [31:0]      mac_a;
    logic [31:0]      mac_b;
    logic             mac_clr;
    logic [31:0]      mac_result;
    logic             m_valid;
    logic             m_ready;
    logic [31:0]      m_result;
    logic [CNT_W-1:0] m_count;

    modport master (
        output s_valid, s_a, s_b, s_last, mac_result, m_ready,
        input  s_ready, mac_a, mac_b, mac_clr, m_valid, m_result, m_count
    );

    modport slave (
        input  s_valid, s_a, s_b, s_last, mac_result, m_ready,
        output s_ready, mac_a, mac_b, mac_clr, m_valid, m_result, m_count
    );
endinterface

// File: rtl/mac_dot_product_feeder.sv
// Operand sequencer for an FP32 MAC core: buffers (a,b,last) pairs, clears the
// core, streams one pair per cycle, then captures the dot product for handoff.
module mac_dot_product_feeder #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    mac_dot_product_feeder_if.slave  bus
);
    localparam int ENTRY_W = 65;
    localparam logic [ADDR_W:0]  PTR_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    typedef enum logic [1:0] {CLEAR, FEED, DRAIN, HOLD} state_t;

    state_t             state_q, state_d;
    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [ENTRY_W-1:0] mem_d [DEPTH];
    logic [ADDR_W:0]    wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        mac_a_q, mac_a_d;
    logic [31:0]        mac_b_q, mac_b_d;
    logic               mac_clr_q, mac_clr_d;
    logic               m_valid_q, m_valid_d;
    logic [31:0]        m_result_q, m_result_d;
    logic [CNT_W-1:0]   m_count_q, m_count_d;

    logic               empty, full, push, pop;
    logic [ENTRY_W-1:0] head;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                   (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    assign push  = bus.s_valid && !full;
    assign pop   = (state_q == FEED) && !empty;
    assign head  = mem_q[rd_ptr_q[ADDR_W-1:0]];

    always_comb begin
        state_d    = state_q;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        m_valid_d  = m_valid_q;
        m_result_d = m_result_q;
        m_count_d  = m_count_q;

        if (push) begin
            mem_d[wr_ptr_q[ADDR_W-1:0]] = {bus.s_a, bus.s_b, bus.s_last};
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        case (state_q)
            CLEAR: begin
                cnt_d   = '0;
                state_d = FEED;
            end
            FEED: begin
                if (pop) begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (head[0]) state_d = DRAIN;
                end
            end
            DRAIN: begin
                // The last operands are at the core this cycle, so the
                // accumulator output already includes the final product.
                m_result_d = bus.mac_result;
                m_count_d  = cnt_q;
                m_valid_d  = 1'b1;
                state_d    = HOLD;
            end
            HOLD: begin
                if (m_valid_q && bus.m_ready) begin
                    m_valid_d = 1'b0;
                    state_d   = CLEAR;
                end
            end
            default: state_d = CLEAR;
        endcase

        // Bubbles and non-FEED states present +0*+0 so the sum holds.
        mac_a_d   = pop ? head[64:33] : 32'h0;
        mac_b_d   = pop ? head[32:1]  : 32'h0;
        mac_clr_d = (state_d == CLEAR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= CLEAR;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            mac_a_q    <= '0;
            mac_b_q    <= '0;
            mac_clr_q  <= 1'b1;
            m_valid_q  <= 1'b0;
            m_result_q <= '0;
            m_count_q  <= '0;
        end else begin
            state_q    <= state_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            mac_a_q    <= mac_a_d;
            mac_b_q    <= mac_b_d;
            mac_clr_q  <= mac_clr_d;
            m_valid_q  <= m_valid_d;
            m_result_q <= m_result_d;
            m_count_q  <= m_count_d;
        end
    end

    assign bus.s_ready  = !full;
    assign bus.mac_a    = mac_a_q;
    assign bus.mac_b    = mac_b_q;
    assign bus.mac_clr  = mac_clr_q;
    assign bus.m_valid  = m_valid_q;
    assign bus.m_result = m_result_q;
    assign bus.m_count  = m_count_q;
endmodule

// File: tb/tb_mac_dot_product_feeder.sv
// Directed bench: a behavioural MAC core closes the loop, a vector-level model
// predicts each dot product, and literal checks pin the model's values.
module tb_mac_dot_product_feeder;
    localparam int DEPTH = 8;
    localparam int CNT_W = 16;

    typedef struct {
        logic [31:0]      r;
        logic [CNT_W-1:0] c;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    int   res_seen = 0;
    logic [31:0]      last_res;
    logic [CNT_W-1:0] last_cnt;
    exp_t             exp_q[$];
    logic [31:0]      fed_q[$];
    logic [31:0]      va[$];
    logic [31:0]      vb[$];
    logic [31:0]      acc = 32'h0;
    logic             hold_prev = 1'b0;
    logic [31:0]      prev_res;
    logic [CNT_W-1:0] prev_cnt;

    mac_dot_product_feeder_if #(.CNT_W(CNT_W)) bus ();

    mac_dot_product_feeder #(.DEPTH(DEPTH), .ADDR_W(3), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        logic [10:0] e;
        if (f[30:0] == 31'h0) return 0.0;
        e = {3'b0, f[30:23]} + 11'd896;
        d = {f[31], e, f[22:0], 29'h0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        if (d[62:0] == 63'h0) return 32'h0;
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    // MAC core: output is accumulator plus the current product; mac_clr clears it.
    assign bus.mac_result = r2f(f2r(acc) + f2r(bus.mac_a) * f2r(bus.mac_b));
    always @(posedge clk) acc <= bus.mac_clr ? 32'h0 : bus.mac_result;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Per-cycle compare of results against the vector model.
    always @(negedge clk) begin
        if (rst) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev && bus.m_valid) begin
                chk("hold_result", bus.m_result, prev_res);
                chk("hold_count", 32'(bus.m_count), 32'(prev_cnt));
            end
            if (bus.mac_a != 32'h0) fed_q.push_back(bus.mac_a);
            if (bus.m_valid && bus.m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 32'h1, 32'h0);
                end else begin
                    chk("model_result", bus.m_result, exp_q[0].r);
                    chk("model_count", 32'(bus.m_count), 32'(exp_q[0].c));
                    void'(exp_q.pop_front());
                end
                last_res = bus.m_result;
                last_cnt = bus.m_count;
                res_seen++;
            end
            hold_prev = bus.m_valid && !bus.m_ready;
            prev_res  = bus.m_result;
            prev_cnt  = bus.m_count;
        end
    end

    task automatic send_pair(input logic [31:0] a, input logic [31:0] b, input logic last);
        logic rdy;
        int   t = 0;
        bus.s_valid = 1'b1;
        bus.s_a = a;
        bus.s_b = b;
        bus.s_last = last;
        forever begin
            @(negedge clk) rdy = bus.s_ready;
            @(posedge clk); #1;
            t++;
            if (rdy) break;
            if (t > 200) begin
                chk("push_timeout", 32'(t), 32'h0);
                break;
            end
        end
        bus.s_valid = 1'b0;
    endtask

    // Sends va/vb as one vector, optionally idling gap cycles after element gap_at.
    task automatic send_vec(input int gap_at, input int gap);
        exp_t e;
        real  s = 0.0;
        for (int i = 0; i < va.size(); i++) s = s + f2r(va[i]) * f2r(vb[i]);
        e.r = r2f(s);
        e.c = CNT_W'(va.size());
        exp_q.push_back(e);
        for (int i = 0; i < va.size(); i++) begin
            send_pair(va[i], vb[i], i == va.size() - 1);
            if (i == gap_at) repeat (gap) begin @(posedge clk); #1; end
        end
        va.delete();
        vb.delete();
    endtask

    task automatic wait_results(input int target);
        int t = 0;
        while (res_seen < target && t < 300) begin @(posedge clk); #1; t++; end
        if (res_seen < target) chk("result_timeout", 32'(res_seen), 32'(target));
    endtask

    task automatic wait_mvalid();
        int t = 0;
        while (!bus.m_valid && t < 300) begin @(posedge clk); #1; t++; end
        chk("m_valid_seen", 32'(bus.m_valid), 32'h1);
    endtask

    initial begin
        bus.s_valid = 1'b0;
        bus.s_a = '0;
        bus.s_b = '0;
        bus.s_last = 1'b0;
        bus.m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state, then a single clear cycle.
        @(negedge clk);
        chk("rst_mac_clr", 32'(bus.mac_clr), 32'h1);
        chk("rst_m_valid", 32'(bus.m_valid), 32'h0);
        chk("rst_s_ready", 32'(bus.s_ready), 32'h1);
        chk("rst_mac_a", bus.mac_a, 32'h0);
        chk("rst_mac_b", bus.mac_b, 32'h0);
        chk("rst_m_result", bus.m_result, 32'h0);
        chk("rst_m_count", 32'(bus.m_count), 32'h0);
        @(negedge clk);
        chk("clr_released", 32'(bus.mac_clr), 32'h0);
        @(posedge clk); #1;

        // 1*2 + 3*4 = 14
        bus.m_ready = 1'b1;
        va = '{32'h3F800000, 32'h40400000};
        vb = '{32'h40000000, 32'h40800000};
        send_vec(-1, 0);
        wait_results(1);
        chk("t2_result", last_res, 32'h41600000);
        chk("t2_count", 32'(last_cnt), 32'h2);

        // Same vector with a 3-cycle gap, bubbles must not disturb the sum.
        va = '{32'h3F800000, 32'h40400000};
        vb = '{32'h40000000, 32'h40800000};
        send_vec(0, 3);
        wait_results(2);
        chk("t3_result", last_res, 32'h41600000);
        chk("t3_count", 32'(last_cnt), 32'h2);

        // Back-to-back vectors with the consumer stalled.
        bus.m_ready = 1'b0;
        va = '{32'h40000000};
        vb = '{32'h40000000};
        send_vec(-1, 0);
        va = '{32'h3F800000, 32'h3F800000};
        vb = '{32'h3F800000, 32'h3F800000};
        send_vec(-1, 0);
        wait_mvalid();
        repeat (5) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("t4_held_valid", 32'(bus.m_valid), 32'h1);
        chk("t4_held_result", bus.m_result, 32'h40800000);
        chk("t4_held_count", 32'(bus.m_count), 32'h1);
        @(posedge clk); #1;
        bus.m_ready = 1'b1;
        wait_results(3);
        chk("t4_first_count", 32'(last_cnt), 32'h1);
        wait_results(4);
        chk("t4_second_result", last_res, 32'h40000000);
        chk("t4_second_count", 32'(last_cnt), 32'h2);

        // Fill the FIFO while holding a result; the extra pair must be refused.
        bus.m_ready = 1'b0;
        va = '{32'h40400000};
        vb = '{32'h3F800000};
        send_vec(-1, 0);
        wait_mvalid();
        fed_q.delete();
        va = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
               32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
        vb = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000,
               32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000};
        send_vec(-1, 0);
        bus.s_valid = 1'b1;
        bus.s_a = 32'h42C80000;
        bus.s_b = 32'h3F800000;
        bus.s_last = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t5_full_s_ready", 32'(bus.s_ready), 32'h0);
            @(posedge clk); #1;
        end
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b1;
        wait_results(5);
        chk("t5_single_result", last_res, 32'h40400000);
        wait_results(6);
        chk("t5_full_result", last_res, 32'h42100000);
        chk("t5_full_count", 32'(last_cnt), 32'h8);
        chk("t5_fed_len", 32'(fed_q.size()), 32'h8);
        for (int i = 0; i < 8; i++)
            chk("t5_fed_order", (i < fed_q.size()) ? fed_q[i] : 32'hDEADBEEF, va_ref(i));
        repeat (4) begin @(posedge clk); #1; end
        chk("t5_no_extra", 32'(res_seen), 32'h6);

        // Reset in the middle of a 4-element vector.
        send_pair(32'h3F800000, 32'h3F800000, 1'b0);
        send_pair(32'h40000000, 32'h3F800000, 1'b0);
        send_pair(32'h40400000, 32'h3F800000, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_s_ready", 32'(bus.s_ready), 32'h1);
        chk("t6_rst_m_valid", 32'(bus.m_valid), 32'h0);
        chk("t6_rst_mac_clr", 32'(bus.mac_clr), 32'h1);
        chk("t6_rst_mac_a", bus.mac_a, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        va = '{32'h40000000};
        vb = '{32'h40400000};
        send_vec(-1, 0);
        wait_results(7);
        chk("t6_after_result", last_res, 32'h40C00000);
        chk("t6_after_count", 32'(last_cnt), 32'h1);
        chk("exp_drained", 32'(exp_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    function automatic logic [31:0] va_ref(input int i);
        logic [31:0] tbl [8];
        tbl = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
        return tbl[i];
    endfunction
endmodule
